fp_div_nr: RTL and testbench

Multi-cycle floating-point divider, the consumer of the Newton-Raphson reciprocal significand stage. It accepts packed dividend and divisor operands, unpacks them, and iterates the reciprocal refinement x(i+1) = x(i)*(2 - b*x(i)) on the divisor significand for ITER cycles. It then multiplies the dividend significand by the reciprocal, corrects the quotient to an exact truncated result, and normalises and packs it. Sits in the FPU execute path behind a valid/ready handshake.

---
 rtl/fpu_pkg.sv | 42 ++++
 rtl/nr_recip_step.sv | 27 ++
 rtl/fp_div_nr.sv | 207 ++++++++++++++++++++
 tb/tb_fp_div_nr.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared definitions for the floating-point divider: FSM states, flag
// positions, exponent bias and special-value encodings.
package fpu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ITER = 3'd1,
    ST_MUL  = 3'd2,
    ST_CORR = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  localparam int FLG_INV = 3;
  localparam int FLG_DBZ = 2;
  localparam int FLG_OVF = 1;
  localparam int FLG_UNF = 0;

  function automatic int fp_bias(input int nexp);
    return (1 << (nexp - 1)) - 1;
  endfunction

  function automatic logic [63:0] fp_exp_field(input logic [63:0] op, input int nexp, input int nsig);
    return (op >> nsig) & ((64'd1 << nexp) - 64'd1);
  endfunction

  function automatic logic [63:0] fp_frac_field(input logic [63:0] op, input int nsig);
    return op & ((64'd1 << nsig) - 64'd1);
  endfunction

  function automatic logic [63:0] fp_zero(input logic s, input int nexp, input int nsig);
    return {63'd0, s} << (nexp + nsig);
  endfunction

  function automatic logic [63:0] fp_inf(input logic s, input int nexp, input int nsig);
    return fp_zero(s, nexp, nsig) | (((64'd1 << nexp) - 64'd1) << nsig);
  endfunction

  function automatic logic [63:0] fp_qnan(input int nexp, input int nsig);
    return fp_inf(1'b0, nexp, nsig) | (64'd1 << (nsig - 1));
  endfunction

endpackage

// File: rtl/nr_recip_step.sv
// One Newton-Raphson reciprocal refinement x*(2 - b*x) in unsigned fixed
// point with 2 integer bits; the result is truncated back to W bits.
module nr_recip_step
  import fpu_pkg::*;
#(
  parameter int W = 18
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] b,
  output logic [W-1:0] x_next
);
  localparam int F = W - 2;
  localparam logic [2*W-1:0] TWO = {{(2*W-2){1'b0}}, 2'b10} << (2*F);

  logic [2*W-1:0] bx_s;
  logic [2*W-1:0] t_s;
  logic [3*W-1:0] p_s;

  // b*x and 2-b*x are kept exact so the only rounding is the final truncation.
  always_comb begin
    bx_s   = {{W{1'b0}}, b} * {{W{1'b0}}, x};
    t_s    = TWO - bx_s;
    p_s    = {{(2*W){1'b0}}, x} * {{W{1'b0}}, t_s};
    x_next = W'(p_s >> (2*F));
  end

endmodule

// File: rtl/fp_div_nr.sv
// Multi-cycle floating-point divider: Newton-Raphson reciprocal, multiply,
// one-ulp correction to an exact truncated quotient, normalise and pack.
module fp_div_nr
  import fpu_pkg::*;
#(
  parameter int NEXP = 8,
  parameter int NSIG = 7,
  parameter int ITER = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [NEXP+NSIG:0] a,
  input  logic [NEXP+NSIG:0] b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [NEXP+NSIG:0] q,
  output logic [3:0]         flags
);
  localparam int N  = 1 + NEXP + NSIG;
  localparam int M  = NSIG + 1;
  localparam int W  = 2 * M + 2;
  localparam int F  = W - 2;
  localparam int QW = NSIG + 3;
  localparam int EW = NEXP + 2;
  localparam int RW = QW + M + 1;

  localparam logic [EW-1:0] BIAS_E   = EW'(fp_bias(NEXP));
  localparam logic [EW-1:0] ONE_E    = {{(EW-1){1'b0}}, 1'b1};
  localparam logic [EW-1:0] ZERO_E   = {EW{1'b0}};
  localparam logic [EW-1:0] EMAX_E   = {2'b00, {NEXP{1'b1}}};
  localparam logic [W-1:0]  X0       = {2'b00, 2'b11, {(F-2){1'b0}}};
  localparam logic [2:0]    CNT_LAST = 3'(ITER - 1);

  state_e          state_r, state_n;
  logic [2:0]      cnt_r;
  logic            sign_r, spec_r;
  logic [EW-1:0]   exp_r;
  logic [M-1:0]    ma_r, mb_r;
  logic [W-1:0]    x_r, x_next_s, ma_q_s, mb_q_s;
  logic [QW-1:0]   qm_r, qm_mul_s, qm_corr_s, norm_s;
  logic [N-1:0]    spec_q_r, spec_q_s, res_q_s, q_r;
  logic [3:0]      spec_flags_r, spec_flags_s, res_flags_s, flags_r;
  logic            out_valid_r, in_ready_r;
  logic            accept_s, take_s, load_out_s;
  logic [NEXP-1:0] ea_s, eb_s;
  logic [NSIG-1:0] fa_s, fb_s;
  logic            sign_s, spec_s;
  logic            a_zero_s, a_inf_s, a_nan_s, b_zero_s, b_inf_s, b_nan_s;
  logic [EW-1:0]   exp_t_s, exp_n_s;
  logic [2*W-1:0]  prod_s;
  logic [QW+M-1:0] qmb_s;
  logic [RW-1:0]   r_s;

  // Unpack operands and resolve special operands at accept time.
  always_comb begin
    ea_s     = NEXP'(fp_exp_field(64'(a), NEXP, NSIG));
    eb_s     = NEXP'(fp_exp_field(64'(b), NEXP, NSIG));
    fa_s     = NSIG'(fp_frac_field(64'(a), NSIG));
    fb_s     = NSIG'(fp_frac_field(64'(b), NSIG));
    sign_s   = a[N-1] ^ b[N-1];
    a_zero_s = (ea_s == {NEXP{1'b0}});
    b_zero_s = (eb_s == {NEXP{1'b0}});
    a_inf_s  = (ea_s == {NEXP{1'b1}}) && (fa_s == {NSIG{1'b0}});
    b_inf_s  = (eb_s == {NEXP{1'b1}}) && (fb_s == {NSIG{1'b0}});
    a_nan_s  = (ea_s == {NEXP{1'b1}}) && (fa_s != {NSIG{1'b0}});
    b_nan_s  = (eb_s == {NEXP{1'b1}}) && (fb_s != {NSIG{1'b0}});
    exp_t_s  = {2'b00, ea_s} - {2'b00, eb_s} + BIAS_E;
    spec_s       = 1'b1;
    spec_flags_s = 4'b0000;
    if (a_nan_s || b_nan_s || (a_zero_s && b_zero_s) || (a_inf_s && b_inf_s)) begin
      spec_q_s              = N'(fp_qnan(NEXP, NSIG));
      spec_flags_s[FLG_INV] = 1'b1;
    end else if (a_inf_s) begin
      spec_q_s = N'(fp_inf(sign_s, NEXP, NSIG));
    end else if (b_zero_s) begin
      spec_q_s              = N'(fp_inf(sign_s, NEXP, NSIG));
      spec_flags_s[FLG_DBZ] = 1'b1;
    end else if (a_zero_s || b_inf_s) begin
      spec_q_s = N'(fp_zero(sign_s, NEXP, NSIG));
    end else begin
      spec_s   = 1'b0;
      spec_q_s = {N{1'b0}};
    end
  end

  nr_recip_step #(.W(W)) u_step (
    .x      (x_r),
    .b      (mb_q_s),
    .x_next (x_next_s)
  );

  // Quotient estimate, then exact remainder test: r = ma - qm*mb scaled to integers.
  always_comb begin
    ma_q_s   = {1'b0, ma_r, {(F-NSIG){1'b0}}};
    mb_q_s   = {1'b0, mb_r, {(F-NSIG){1'b0}}};
    prod_s   = {{W{1'b0}}, ma_q_s} * {{W{1'b0}}, x_r};
    qm_mul_s = QW'(prod_s >> (2*F - NSIG - 2));
    qmb_s    = {{M{1'b0}}, qm_r} * {{QW{1'b0}}, mb_r};
    r_s      = {2'b00, ma_r, {(NSIG+2){1'b0}}} - {1'b0, qmb_s};
    if (r_s[RW-1]) begin
      qm_corr_s = qm_r - {{(QW-1){1'b0}}, 1'b1};
    end else if (r_s >= {{(RW-M){1'b0}}, mb_r}) begin
      qm_corr_s = qm_r + {{(QW-1){1'b0}}, 1'b1};
    end else begin
      qm_corr_s = qm_r;
    end
  end

  // Normalise, range-check and pack the final result.
  always_comb begin
    norm_s      = qm_r[QW-1] ? qm_r : {qm_r[QW-2:0], 1'b0};
    exp_n_s     = qm_r[QW-1] ? exp_r : exp_r - ONE_E;
    res_flags_s = 4'b0000;
    if (spec_r) begin
      res_q_s     = spec_q_r;
      res_flags_s = spec_flags_r;
    end else if ($signed(exp_n_s) >= $signed(EMAX_E)) begin
      res_q_s              = N'(fp_inf(sign_r, NEXP, NSIG));
      res_flags_s[FLG_OVF] = 1'b1;
    end else if ($signed(exp_n_s) <= $signed(ZERO_E)) begin
      res_q_s              = N'(fp_zero(sign_r, NEXP, NSIG));
      res_flags_s[FLG_UNF] = 1'b1;
    end else begin
      res_q_s = {sign_r, NEXP'(exp_n_s), NSIG'(norm_s >> 2)};
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= ST_IDLE;
    else        state_r <= state_n;
  end

  // Next-state logic.
  always_comb begin
    state_n = state_r;
    case (state_r)
      ST_IDLE: if (accept_s) state_n = ST_ITER; else state_n = ST_IDLE;
      ST_ITER: if (cnt_r == CNT_LAST) state_n = ST_MUL; else state_n = ST_ITER;
      ST_MUL:  state_n = ST_CORR;
      ST_CORR: state_n = ST_DONE;
      ST_DONE: if (take_s) state_n = ST_IDLE; else state_n = ST_DONE;
      default: state_n = ST_IDLE;
    endcase
  end

  // Handshake decode; the first DONE cycle loads the output registers.
  always_comb begin
    accept_s   = in_valid && in_ready_r && (state_r == ST_IDLE);
    take_s     = out_valid_r && out_ready;
    load_out_s = (state_r == ST_DONE) && !out_valid_r;
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= 3'd0; sign_r <= 1'b0; spec_r <= 1'b0; exp_r <= {EW{1'b0}};
      ma_r <= {M{1'b0}}; mb_r <= {M{1'b0}}; x_r <= {W{1'b0}}; qm_r <= {QW{1'b0}};
      spec_q_r <= {N{1'b0}}; spec_flags_r <= 4'b0000;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            cnt_r <= 3'd0; sign_r <= sign_s; spec_r <= spec_s; exp_r <= exp_t_s;
            ma_r <= {1'b1, fa_s}; mb_r <= {1'b1, fb_s}; x_r <= X0;
            spec_q_r <= spec_q_s; spec_flags_r <= spec_flags_s;
          end else begin
            cnt_r <= cnt_r;
          end
        end
        ST_ITER: begin
          x_r   <= x_next_s;
          cnt_r <= cnt_r + 3'd1;
        end
        ST_MUL:  qm_r <= qm_mul_s;
        ST_CORR: qm_r <= qm_corr_s;
        default: cnt_r <= cnt_r;
      endcase
    end
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready_r <= 1'b1; out_valid_r <= 1'b0; q_r <= {N{1'b0}}; flags_r <= 4'b0000;
    end else begin
      in_ready_r <= (state_n == ST_IDLE);
      if (load_out_s) begin
        out_valid_r <= 1'b1;
        q_r         <= res_q_s;
        flags_r     <= res_flags_s;
      end else if (take_s) begin
        out_valid_r <= 1'b0;
      end else begin
        out_valid_r <= out_valid_r;
      end
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign q         = q_r;
  assign flags     = flags_r;

endmodule

// File: tb/tb_fp_div_nr.sv
// Randomised self-checking bench for fp_div_nr against an exact integer-division
// reference of a/b with truncation, plus the directed corner cases.
module tb_fp_div_nr;
  localparam int NEXP = 8;
  localparam int NSIG = 7;
  localparam int ITER = 4;
  localparam int N    = 1 + NEXP + NSIG;

  logic         clk = 1'b0;
  logic         rst_n, in_valid, in_ready, out_valid, out_ready;
  logic [N-1:0] a, b, q;
  logic [3:0]   flags;
  int           n_cmp = 0;
  int           n_err = 0;

  always #5 clk = ~clk;

  fp_div_nr #(.NEXP(NEXP), .NSIG(NSIG), .ITER(ITER)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .q(q), .flags(flags)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  // Reference: exact quotient from integer division, truncated; flags {inv,dbz,ovf,unf}.
  function automatic void ref_div(input logic [15:0] x, input logic [15:0] y,
                                  output logic [15:0] rq, output logic [3:0] rf);
    int ea, eb, fa, fb, e, frac;
    longint qq;
    bit az, ai, an, bz, bi, bn;
    logic s;
    ea = int'(x[14:7]); fa = int'(x[6:0]);
    eb = int'(y[14:7]); fb = int'(y[6:0]);
    az = (ea == 0); ai = (ea == 255) && (fa == 0); an = (ea == 255) && (fa != 0);
    bz = (eb == 0); bi = (eb == 255) && (fb == 0); bn = (eb == 255) && (fb != 0);
    s  = x[15] ^ y[15];
    rf = 4'b0000;
    if (an || bn || (az && bz) || (ai && bi)) begin
      rq = 16'h7FC0; rf = 4'b1000;
    end else if (ai) begin
      rq = {s, 15'h7F80};
    end else if (bz) begin
      rq = {s, 15'h7F80}; rf = 4'b0100;
    end else if (az || bi) begin
      rq = {s, 15'h0000};
    end else begin
      qq = (longint'(128 + fa) * 65536) / longint'(128 + fb);
      e  = ea - eb + 127;
      if (qq < 65536) begin
        e--;
        frac = int'((qq >> 8) & 127);
      end else begin
        frac = int'((qq >> 9) & 127);
      end
      if (e >= 255) begin
        rq = {s, 15'h7F80}; rf = 4'b0010;
      end else if (e <= 0) begin
        rq = {s, 15'h0000}; rf = 4'b0001;
      end else begin
        rq = {s, 8'(e), 7'(frac)};
      end
    end
  endfunction

  function automatic logic [15:0] rand_op();
    logic [7:0] e;
    case ($urandom_range(0, 15))
      0:       e = 8'h00;
      1:       e = 8'hFF;
      2:       e = 8'($urandom_range(1, 20));
      3:       e = 8'($urandom_range(235, 254));
      default: e = 8'($urandom_range(90, 165));
    endcase
    return {1'($urandom), e, 7'($urandom)};
  endfunction

  // One transaction: accept, fixed latency, result, optional backpressure, handshake.
  task automatic do_op(input string tag, input logic [15:0] ta, input logic [15:0] tb,
                       input logic [15:0] eq, input logic [3:0] ef, input int stall);
    int lat;
    @(negedge clk);
    chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    a = ta; b = tb; in_valid = 1'b1; out_ready = (stall == 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, ".latency"}, 32'(lat), 32'(ITER + 3));
    chk({tag, ".q"}, 32'(q), 32'(eq));
    chk({tag, ".flags"}, 32'(flags), 32'(ef));
    for (int i = 0; i < stall; i++) begin
      a = rand_op(); b = rand_op(); in_valid = 1'b1;
      @(posedge clk); #1;
      chk({tag, ".hold_valid"}, 32'(out_valid), 32'd1);
      chk({tag, ".hold_q"}, 32'(q), 32'(eq));
      chk({tag, ".busy"}, 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    chk({tag, ".taken"}, 32'(out_valid), 32'd0);
    chk({tag, ".idle"}, 32'(in_ready), 32'd1);
    out_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [15:0] ra, rb, eq;
    logic [3:0]  ef;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = 16'h0000; b = 16'h0000;
    #12;
    chk("reset.in_ready", 32'(in_ready), 32'd1);
    chk("reset.out_valid", 32'(out_valid), 32'd0);
    chk("reset.q", 32'(q), 32'd0);
    chk("reset.flags", 32'(flags), 32'd0);
    @(negedge clk); rst_n = 1'b1;

    do_op("six_by_three", 16'h40C0, 16'h4040, 16'h4000, 4'b0000, 0);
    do_op("one_third",    16'h3F80, 16'h4040, 16'h3EAA, 4'b0000, 0);
    do_op("one_half",     16'h3F80, 16'h4000, 16'h3F00, 4'b0000, 0);
    do_op("div_zero",     16'hC000, 16'h0000, 16'hFF80, 4'b0100, 0);
    do_op("zero_zero",    16'h0000, 16'h0000, 16'h7FC0, 4'b1000, 0);
    do_op("overflow",     16'h7F00, 16'h0080, 16'h7F80, 4'b0010, 0);
    do_op("underflow",    16'h0080, 16'h7F00, 16'h0000, 4'b0001, 0);
    do_op("inf_finite",   16'hFF80, 16'h4040, 16'hFF80, 4'b0000, 0);
    do_op("finite_inf",   16'h4040, 16'hFF80, 16'h8000, 4'b0000, 0);
    do_op("backpressure", 16'h40C0, 16'h4040, 16'h4000, 4'b0000, 5);

    // Asynchronous reset while iterating abandons the divide.
    @(negedge clk);
    a = 16'h3F80; b = 16'h4040; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0; #1;
    chk("midrst.out_valid", 32'(out_valid), 32'd0);
    chk("midrst.in_ready", 32'(in_ready), 32'd1);
    chk("midrst.q", 32'(q), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    do_op("after_reset", 16'h3F80, 16'h4040, 16'h3EAA, 4'b0000, 0);

    for (int i = 0; i < 200; i++) begin
      ra = rand_op(); rb = rand_op();
      ref_div(ra, rb, eq, ef);
      do_op($sformatf("rand%0d_%h_%h", i, ra, rb), ra, rb, eq, ef, int'($urandom_range(0, 2)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
